dac_burst_sequencer: RTL and testbench
======================================

# dac_burst_sequencer

Generates the transmit tone burst for the ultrasound positioning emitter as a stream of DAC codes, one code per handshake. Sits directly upstream of the serial DAC driver (the `din`/`sync`/`clk_out` block): the driver pulls samples with `sample_ready`, and this block supplies a square-wave burst centred on mid-scale, followed by a return-to-mid-scale tail sample. One burst is produced per `start` pulse.

## Interface
- `DATA_W`, 12, DAC code width.
- `MID_CODE`, 2048, idle / centre code (mid-scale).
- `CNT_W`, 8, width of the half-period and cycle-count inputs.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle burst request; accepted only in IDLE.
- `amp`  in  DATA_W  burst amplitude, offset from `MID_CODE`.
- `half_len`  in  CNT_W  samples per half-cycle; 0 is treated as 1.
- `num_cycles`  in  CNT_W  number of full high/low cycles; 0 means tail only.
- `sample`  out  DATA_W  DAC code to the serializer.
- `sample_valid`  out  1  `sample` is valid.
- `sample_ready`  in  1  serializer accepts `sample` this cycle.
- `busy`  out  1  burst in progress, from the accepting cycle through the tail transfer.
- `done`  out  1  one-cycle pulse after the tail sample transfers.

## Operation
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state IDLE, `sample`=`MID_CODE`, `sample_valid`=0, `busy`=0, `done`=0, all counters 0.
- Latching: `start` in IDLE latches `amp`, `half_len` (0→1) and `num_cycles`. Input changes during a burst have no effect. `start` while `busy` is ignored.
- Code arithmetic: computed in DATA_W+1 bits, then saturated.
  - `hi_code` = min(`MID_CODE`+`amp`, 2^DATA_W−1).
  - `lo_code` = max(`MID_CODE`−`amp`, 0).
- States:
  - IDLE → HIGH on `start` if `num_cycles`≠0; otherwise IDLE → TAIL.
  - HIGH: presents `hi_code`. After `half_len` transfers → LOW.
  - LOW: presents `lo_code`. After `half_len` transfers, increment the cycle count. If count = `num_cycles` → TAIL, else → HIGH.
  - TAIL: presents `MID_CODE` once. On transfer → IDLE and pulse `done`.
- Handshake:
  - Transfer occurs when `sample_valid` && `sample_ready`.
  - While `sample_valid`=1 and `sample_ready`=0, `sample` is held stable. `sample_valid` never drops without a transfer.
  - `sample_ready` is ignored while `sample_valid`=0.
- Samples per burst: 2·`half_len`·`num_cycles`+1.
- IDLE outputs: `sample_valid`=0 and `sample`=`MID_CODE`.
- Counters: the half-cycle counter wraps to 0 on each half boundary. The cycle counter is CNT_W bits and never wraps within a burst (maximum 255 cycles).

## Timing
- Latency: `start` sampled high at edge N gives `busy`=1 and `sample_valid`=1, with the first code, after edge N.
- Throughput: one sample per cycle when `sample_ready` is held high. There are no bubbles between states.
- `done`: high for exactly the cycle after the tail-transfer edge. `busy` falls on that same edge.
- A new `start` may be accepted in the same cycle `done` is high, since the state is already IDLE.
- Reset mid-burst: outputs return to their reset values immediately (asynchronous assertion), with no `done` pulse. Release is synchronous to `clk` (the external reset synchroniser handles this).
- `start` and reset deassertion in the same cycle: `start` is ignored.

## Test plan
- **Basic burst.** `amp`=1000, `half_len`=3, `num_cycles`=2, `sample_ready`=1. Stream must be 3×3048, 3×1048, 3×3048, 3×1048, 2048; 13 samples; `done` one cycle after the last.
- **Saturation.** `amp`=2100 → high code 4095, low code 0. `amp`=0 → every code 2048.
- **Backpressure.** `sample_ready` toggled pseudo-randomly during the basic burst. Sequence must be identical; `sample` stable whenever valid && !ready; no dropped or duplicated codes.
- **Degenerate inputs.**
  - `num_cycles`=0: single 2048 sample, then `done`.
  - `half_len`=0, `num_cycles`=1: stream 3048, 1048, 2048.
- **Start while busy and input changes.** Pulse `start` mid-burst and change `amp` to 500 → ignored; burst still uses 1000. A `start` in the `done` cycle launches the next burst immediately.
- **Reset mid-burst.** Assert `rst_n` low during LOW → `sample_valid`=0, `busy`=0, `sample`=2048 with no clock edge; after release, a new `start` runs a clean full burst.

Source files
------------

// File: rtl/dac_burst_sequencer.sv
// Tone-burst sample source for the ultrasound emitter DAC path.
// Square wave around mid-scale, then a single mid-scale tail sample.
module dac_burst_sequencer #(
  parameter int DATA_W   = 12,
  parameter int MID_CODE = 2048,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] amp,
  input  logic [CNT_W-1:0]  half_len,
  input  logic [CNT_W-1:0]  num_cycles,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    TAIL
  } state_t;

  localparam logic [DATA_W:0] MAX_W = {1'b0, {DATA_W{1'b1}}};
  localparam logic [DATA_W:0] MID_W = (DATA_W+1)'(MID_CODE);
  localparam logic [DATA_W-1:0] MID_C = DATA_W'(MID_CODE);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [CNT_W-1:0]  hlen_q, hlen_d;
  logic [CNT_W-1:0]  ncyc_q, ncyc_d;
  logic [CNT_W-1:0]  half_q, half_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              done_q, done_d;
  logic              armed_q;

  logic [DATA_W:0]   amp_w;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   dif_w;
  logic [DATA_W-1:0] hi_new;
  logic [DATA_W-1:0] lo_new;
  logic [CNT_W-1:0]  cyc_inc;
  logic              half_last;
  logic              xfer;

  assign sample_valid = (state_q != IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign xfer         = sample_valid & sample_ready;

  // Saturating code arithmetic, one bit wider than the DAC code
  always_comb begin
    amp_w  = {1'b0, amp};
    sum_w  = MID_W + amp_w;
    dif_w  = MID_W - amp_w;
    hi_new = (sum_w > MAX_W) ? MAX_W[DATA_W-1:0]
                             : sum_w[DATA_W-1:0];
    lo_new = (amp_w > MID_W) ? '0
                             : dif_w[DATA_W-1:0];
  end

  assign half_last = (half_q == hlen_q - CNT_W'(1));
  assign cyc_inc   = cyc_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hlen_d  = hlen_q;
    ncyc_d  = ncyc_q;
    half_d  = half_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // armed_q blocks a start on the release edge of reset
        if (start && armed_q) begin
          hi_d    = hi_new;
          lo_d    = lo_new;
          hlen_d  = (half_len == '0) ? CNT_W'(1) : half_len;
          ncyc_d  = num_cycles;
          half_d  = '0;
          cyc_d   = '0;
          state_d = (num_cycles != '0) ? HIGH : TAIL;
        end
      end
      HIGH: begin
        if (xfer) begin
          if (half_last) begin
            half_d  = '0;
            state_d = LOW;
          end else begin
            half_d = half_q + CNT_W'(1);
          end
        end
      end
      LOW: begin
        if (xfer) begin
          if (half_last) begin
            half_d  = '0;
            cyc_d   = cyc_inc;
            state_d = (cyc_inc == ncyc_q) ? TAIL : HIGH;
          end else begin
            half_d = half_q + CNT_W'(1);
          end
        end
      end
      TAIL: begin
        if (xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sample = MID_C;
    unique case (state_q)
      HIGH:    sample = hi_q;
      LOW:     sample = lo_q;
      default: sample = MID_C;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= MID_C;
      lo_q    <= MID_C;
      hlen_q  <= '0;
      ncyc_q  <= '0;
      half_q  <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hlen_q  <= hlen_d;
      ncyc_q  <= ncyc_d;
      half_q  <= half_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      armed_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dac_burst_sequencer.sv
// Directed bench for dac_burst_sequencer.
// Expected streams are rebuilt from burst parameters.
module tb_dac_burst_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] amp;
  logic [7:0]  half_len;
  logic [7:0]  num_cycles;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        done;

  int n_vec;
  int n_err;
  int edge_cnt;
  int last_xfer;
  int q[$];
  bit prev_stall;
  int prev_sample;

  dac_burst_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .amp          (amp),
    .half_len     (half_len),
    .num_cycles   (num_cycles),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Transfer capture and hold-stable check
  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_code", sample, prev_sample);
        chk("hold_valid", sample_valid, 1);
      end
      if (sample_valid && sample_ready) begin
        q.push_back(int'(sample));
        last_xfer = edge_cnt;
      end
      prev_stall  = sample_valid && !sample_ready;
      prev_sample = sample;
    end
  end

  task automatic run(input int a, input int hl, input int nc,
                     input bit bp, input int poke);
    int he, hi, lo;
    int exp[$];
    bit seen;
    he = (hl == 0) ? 1 : hl;
    hi = (2048 + a > 4095) ? 4095 : 2048 + a;
    lo = (a > 2048) ? 0 : 2048 - a;
    for (int c = 0; c < nc; c++) begin
      for (int k = 0; k < he; k++) exp.push_back(hi);
      for (int k = 0; k < he; k++) exp.push_back(lo);
    end
    exp.push_back(2048);
    q.delete();
    @(negedge clk);
    amp = 12'(a);
    half_len = 8'(hl);
    num_cycles = 8'(nc);
    start = 1'b1;
    sample_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("lat_busy", busy, 1);
    chk("lat_valid", sample_valid, 1);
    chk("lat_code", sample, exp[0]);
    chk("done_clr", done, 0);
    seen = 1'b0;
    for (int i = 1; i < 500 && !seen; i++) begin
      @(negedge clk);
      start = (i == poke);
      if (i == poke) amp = 12'd500;
      sample_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      chk("timeout", 0, 1);
    end else begin
      chk("done_lat", last_xfer, edge_cnt);
      chk("done_busy", busy, 0);
      chk("done_valid", sample_valid, 0);
    end
    chk("len", q.size(), exp.size());
    for (int i = 0; i < q.size() && i < exp.size(); i++)
      chk("code", q[i], exp[i]);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    edge_cnt = 0;
    last_xfer = 0;
    prev_stall = 1'b0;
    prev_sample = 0;
    rst_n = 1'b0;
    start = 1'b0;
    amp = '0;
    half_len = '0;
    num_cycles = '0;
    sample_ready = 1'b0;
    #1;
    chk("rst_code", sample, 2048);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(1000, 3, 2, 1'b0, -1);
    run(1000, 3, 2, 1'b1, -1);
    run(2100, 2, 1, 1'b0, -1);
    run(0, 2, 1, 1'b0, -1);
    run(1000, 3, 0, 1'b0, -1);
    run(1000, 0, 1, 1'b0, -1);
    run(1000, 3, 2, 1'b1, 4);
    // Launches in the done cycle of the previous burst
    run(1000, 1, 1, 1'b0, -1);

    // Reset during LOW
    q.delete();
    @(negedge clk);
    amp = 12'd1000;
    half_len = 8'd3;
    num_cycles = 8'd2;
    start = 1'b1;
    sample_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && q.size() < 4; i++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_code", sample, 1048);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", sample_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_code", sample, 2048);
    chk("arst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_start_ign", busy, 0);
    chk("rel_no_done", done, 0);
    @(negedge clk);
    start = 1'b0;
    run(1000, 3, 2, 1'b0, -1);
    @(posedge clk);
    #1;
    chk("done_pulse", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
